// File: rtl/mmu_sequencer.sv
// mmu_sequencer: job controller for the 2x2 systolic MMU feeder.
// Loads weights/inputs from a host byte stream, runs a fixed compute
// window, captures four int8 results and streams them back.
//
// Optional feature macro: WEIGHT_REUSE_EN (adds host_keep_w; a job may
// reuse the previous weights and load only the four input bytes).
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   host_data/valid/ready       host ingress byte stream
//   result_data/valid/ready     result egress byte stream
//   busy, err                   status (err is sticky until reset)
//   feeder_en, mmu_cycle,
//   output_sel                  feeder control
//   feeder_done, feeder_result  feeder status / selected result
//   weight0..3, input0..3       operand registers to the feeder
//   host_keep_w                 reuse weights (WEIGHT_REUSE_EN only)
module mmu_sequencer #(
   parameter int OUT_FIRST_CYCLE = 2,
   parameter int LAST_CYCLE      = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] host_data,
   input  logic       host_valid,
   output logic       host_ready,
`ifdef WEIGHT_REUSE_EN
   input  logic       host_keep_w,
`endif
   output logic [7:0] result_data,
   output logic       result_valid,
   input  logic       result_ready,
   output logic       busy,
   output logic       err,
   output logic       feeder_en,
   output logic [2:0] mmu_cycle,
   output logic [1:0] output_sel,
   input  logic       feeder_done,
   input  logic [7:0] feeder_result,
   output logic [7:0] weight0,
   output logic [7:0] weight1,
   output logic [7:0] weight2,
   output logic [7:0] weight3,
   output logic [7:0] input0,
   output logic [7:0] input1,
   output logic [7:0] input2,
   output logic [7:0] input3
);

   localparam logic [2:0] FIRST_C = 3'(OUT_FIRST_CYCLE);
   localparam logic [2:0] LAST_C  = 3'(LAST_CYCLE);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  load_cnt_q, load_cnt_d;
   logic [1:0]  res_idx_q, res_idx_d;
   logic [7:0]  w_q   [4];
   logic [7:0]  w_d   [4];
   logic [7:0]  in_q  [4];
   logic [7:0]  in_d  [4];
   logic [7:0]  buf_q [4];
   logic [7:0]  buf_d [4];
   logic        wl_q, wl_d;
   logic        err_q, err_d;
   logic        en_q, en_d;
   logic [2:0]  cyc_q, cyc_d;

   logic        accept;
   logic        res_hs;
   logic        in_window;
   logic [1:0]  sel;
   logic [2:0]  start_slot;
   logic [2:0]  wr_slot;

   assign host_ready   = (state_q == S_IDLE) || (state_q == S_LOAD);
   assign busy         = (state_q != S_IDLE);
   assign result_valid = (state_q == S_DRAIN);
   assign result_data  = buf_q[res_idx_q];
   assign err          = err_q;
   assign feeder_en    = en_q;
   assign mmu_cycle    = cyc_q;
   assign output_sel   = sel;

   assign weight0 = w_q[0];
   assign weight1 = w_q[1];
   assign weight2 = w_q[2];
   assign weight3 = w_q[3];
   assign input0  = in_q[0];
   assign input1  = in_q[1];
   assign input2  = in_q[2];
   assign input3  = in_q[3];

   assign accept = host_valid && host_ready;
   assign res_hs = result_valid && result_ready;

   // Capture window: feeder reports results for these cycle indices.
   assign in_window = (state_q == S_RUN)
                   && (cyc_q >= FIRST_C)
                   && (cyc_q <= LAST_C);
   assign sel = in_window ? 2'(cyc_q - FIRST_C) : 2'd0;

   // A weight-reuse job starts directly at the first input slot.
   always_comb begin
      start_slot = 3'd0;
`ifdef WEIGHT_REUSE_EN
      if (host_keep_w && wl_q) start_slot = 3'd4;
`endif
   end

   assign wr_slot = (state_q == S_IDLE) ? start_slot : load_cnt_q;

   always_comb begin
      state_d    = state_q;
      load_cnt_d = load_cnt_q;
      res_idx_d  = res_idx_q;
      w_d        = w_q;
      in_d       = in_q;
      buf_d      = buf_q;
      wl_d       = wl_q;
      err_d      = err_q;
      en_d       = en_q;
      cyc_d      = cyc_q;

      // Slot 0-3 -> weights, 4-7 -> inputs.
      if (accept) begin
         if (wr_slot[2]) in_d[wr_slot[1:0]] = host_data;
         else            w_d[wr_slot[1:0]]  = host_data;
      end

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               load_cnt_d = wr_slot + 3'd1;
               state_d    = S_LOAD;
            end
         end
         S_LOAD: begin
            if (accept) begin
               if (load_cnt_q == 3'd7) begin
                  load_cnt_d = 3'd0;
                  wl_d       = 1'b1;
                  en_d       = 1'b1;
                  cyc_d      = 3'd0;
                  state_d    = S_RUN;
               end else begin
                  load_cnt_d = load_cnt_q + 3'd1;
               end
            end
         end
         S_RUN: begin
            cyc_d = cyc_q + 3'd1;
            // Capture happens even when the feeder is not done;
            // the miss is only flagged through err.
            if (in_window) begin
               buf_d[sel] = feeder_result;
               if (!feeder_done) err_d = 1'b1;
            end
            if (cyc_q == LAST_C) begin
               en_d      = 1'b0;
               cyc_d     = 3'd0;
               res_idx_d = 2'd0;
               state_d   = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (res_hs) begin
               res_idx_d = res_idx_q + 2'd1;
               if (res_idx_q == 2'd3) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         load_cnt_q <= 3'd0;
         res_idx_q  <= 2'd0;
         for (int i = 0; i < 4; i++) begin
            w_q[i]   <= 8'd0;
            in_q[i]  <= 8'd0;
            buf_q[i] <= 8'd0;
         end
         wl_q       <= 1'b0;
         err_q      <= 1'b0;
         en_q       <= 1'b0;
         cyc_q      <= 3'd0;
      end else begin
         state_q    <= state_d;
         load_cnt_q <= load_cnt_d;
         res_idx_q  <= res_idx_d;
         w_q        <= w_d;
         in_q       <= in_d;
         buf_q      <= buf_d;
         wl_q       <= wl_d;
         err_q      <= err_d;
         en_q       <= en_d;
         cyc_q      <= cyc_d;
      end
   end

endmodule

// File: tb/tb_mmu_sequencer.sv
// tb_mmu_sequencer: directed self-checking bench for mmu_sequencer.
// Feeder is stubbed: result = 0x10 + output_sel.
module tb_mmu_sequencer;

   logic       clk;
   logic       rst_n;
   logic [7:0] host_data;
   logic       host_valid;
   logic       host_ready;
`ifdef WEIGHT_REUSE_EN
   logic       host_keep_w;
`endif
   logic [7:0] result_data;
   logic       result_valid;
   logic       result_ready;
   logic       busy;
   logic       err;
   logic       feeder_en;
   logic [2:0] mmu_cycle;
   logic [1:0] output_sel;
   logic       feeder_done;
   logic [7:0] feeder_result;
   logic [7:0] weight0, weight1, weight2, weight3;
   logic [7:0] input0, input1, input2, input3;

   logic       done_low3;
   int         checks;
   int         errors;

   mmu_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .host_data     (host_data),
      .host_valid    (host_valid),
      .host_ready    (host_ready),
`ifdef WEIGHT_REUSE_EN
      .host_keep_w   (host_keep_w),
`endif
      .result_data   (result_data),
      .result_valid  (result_valid),
      .result_ready  (result_ready),
      .busy          (busy),
      .err           (err),
      .feeder_en     (feeder_en),
      .mmu_cycle     (mmu_cycle),
      .output_sel    (output_sel),
      .feeder_done   (feeder_done),
      .feeder_result (feeder_result),
      .weight0       (weight0),
      .weight1       (weight1),
      .weight2       (weight2),
      .weight3       (weight3),
      .input0        (input0),
      .input1        (input1),
      .input2        (input2),
      .input3        (input3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign feeder_result = 8'h10 + {6'd0, output_sel};
   assign feeder_done   = !(done_low3 && mmu_cycle == 3'd3);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d);
      host_valid = 1'b1;
      host_data  = d;
      for (int i = 0; i < 50 && !host_ready; i++) step();
      if (!host_ready) begin
         errors++;
         checks++;
         $display("FAIL send_byte timeout: host_ready=%0b required 1",
                  host_ready);
      end else begin
         step();
      end
      host_valid = 1'b0;
   endtask

   task automatic send_job(input logic [7:0] base);
      for (int i = 0; i < 8; i++) send_byte(base + 8'(i));
   endtask

   task automatic wait_idle();
      result_ready = 1'b1;
      for (int i = 0; i < 60 && busy; i++) step();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL wait_idle: busy=%0b required 0", busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      checks++;
      if (host_ready !== 1'b1 || busy !== 1'b0 || feeder_en !== 1'b0
          || result_valid !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: rdy=%0b busy=%0b en=%0b rv=%0b err=%0b required 1 0 0 0 0",
                  host_ready, busy, feeder_en, result_valid, err);
      end
      // Abort mid-LOAD with the asynchronous reset.
      send_byte(8'h55);
      send_byte(8'h66);
      send_byte(8'h77);
      checks++;
      if (weight0 !== 8'h55 || busy !== 1'b1) begin
         errors++;
         $display("FAIL midload: w0=%h busy=%0b required 55 1",
                  weight0, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (host_ready !== 1'b1 || busy !== 1'b0 || feeder_en !== 1'b0
          || err !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_ctl: rdy=%0b busy=%0b en=%0b err=%0b required 1 0 0 0",
                  host_ready, busy, feeder_en, err);
      end
      checks++;
      if ({weight0, weight1, weight2, weight3,
           input0, input1, input2, input3} !== 64'd0) begin
         errors++;
         $display("FAIL async_reset_regs: w=%h %h %h %h i=%h %h %h %h required all 0",
                  weight0, weight1, weight2, weight3,
                  input0, input1, input2, input3);
      end
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_basic_job();
      send_job(8'd1);
      checks++;
      if ({weight0, weight1, weight2, weight3} !== 32'h01020304
          || {input0, input1, input2, input3} !== 32'h05060708) begin
         errors++;
         $display("FAIL basic_load: w=%h%h%h%h i=%h%h%h%h required 01020304 05060708",
                  weight0, weight1, weight2, weight3,
                  input0, input1, input2, input3);
      end
      for (int k = 0; k < 6; k++) begin
         logic [1:0] esel;
         esel = (k >= 2) ? 2'(k - 2) : 2'd0;
         checks++;
         if (feeder_en !== 1'b1 || mmu_cycle !== 3'(k)
             || output_sel !== esel || result_valid !== 1'b0
             || host_ready !== 1'b0) begin
            errors++;
            $display("FAIL run_cycle%0d: en=%0b cyc=%0d sel=%0d rv=%0b rdy=%0b required 1 %0d %0d 0 0",
                     k, feeder_en, mmu_cycle, output_sel,
                     result_valid, host_ready, k, esel);
         end
         step();
      end
      // Seventh cycle after the last accept: first result.
      checks++;
      if (feeder_en !== 1'b0 || mmu_cycle !== 3'd0
          || result_valid !== 1'b1) begin
         errors++;
         $display("FAIL drain_entry: en=%0b cyc=%0d rv=%0b required 0 0 1",
                  feeder_en, mmu_cycle, result_valid);
      end
      result_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (result_valid !== 1'b1 || result_data !== 8'h10 + 8'(i)) begin
            errors++;
            $display("FAIL result%0d: rv=%0b data=%h required 1 %h",
                     i, result_valid, result_data, 8'h10 + 8'(i));
         end
         step();
      end
      checks++;
      if (busy !== 1'b0 || host_ready !== 1'b1 || result_valid !== 1'b0
          || err !== 1'b0) begin
         errors++;
         $display("FAIL basic_idle: busy=%0b rdy=%0b rv=%0b err=%0b required 0 1 0 0",
                  busy, host_ready, result_valid, err);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_d [8];
      exp_d = '{8'h10, 8'h11, 8'h11, 8'h11, 8'h11, 8'h12, 8'h13, 8'h00};
      result_ready = 1'b0;
      send_job(8'h21);
      host_valid = 1'b1;
      host_data  = 8'hAA;
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (host_ready !== 1'b0) begin
            errors++;
            $display("FAIL run_not_ready%0d: host_ready=%0b required 0",
                     k, host_ready);
         end
         step();
      end
      host_valid = 1'b0;
      checks++;
      if ({input0, input1, input2, input3} !== 32'h25262728
          || weight0 !== 8'h21) begin
         errors++;
         $display("FAIL run_no_consume: i=%h%h%h%h w0=%h required 25262728 21",
                  input0, input1, input2, input3, weight0);
      end
      // Byte 1 held for three cycles with result_ready low.
      for (int i = 0; i < 7; i++) begin
         result_ready = !(i >= 1 && i <= 3);
         checks++;
         if (result_valid !== 1'b1 || result_data !== exp_d[i]) begin
            errors++;
            $display("FAIL bp_beat%0d: rv=%0b data=%h required 1 %h",
                     i, result_valid, result_data, exp_d[i]);
         end
         step();
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_idle: busy=%0b required 0", busy);
      end
   endtask

   task automatic test_error();
      done_low3 = 1'b1;
      send_job(8'h31);
      wait_idle();
      done_low3 = 1'b0;
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL err_set: err=%0b required 1", err);
      end
      send_job(8'h41);
      wait_idle();
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: err=%0b required 1", err);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_reset: err=%0b required 0", err);
      end
      step();
      rst_n = 1'b1;
   endtask

`ifdef WEIGHT_REUSE_EN
   task automatic test_weight_reuse();
      // No weights loaded yet: keep is ignored, full load required.
      host_keep_w = 1'b1;
      for (int i = 1; i <= 4; i++) send_byte(8'(i));
      checks++;
      if (feeder_en !== 1'b0 || host_ready !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL reuse_cold: en=%0b rdy=%0b busy=%0b required 0 1 1",
                  feeder_en, host_ready, busy);
      end
      for (int i = 5; i <= 8; i++) send_byte(8'(i));
      checks++;
      if (feeder_en !== 1'b1
          || {weight0, weight1, weight2, weight3} !== 32'h01020304) begin
         errors++;
         $display("FAIL reuse_full: en=%0b w=%h%h%h%h required 1 01020304",
                  feeder_en, weight0, weight1, weight2, weight3);
      end
      wait_idle();
      for (int i = 9; i <= 12; i++) send_byte(8'(i));
      checks++;
      if (feeder_en !== 1'b1
          || {weight0, weight1, weight2, weight3} !== 32'h01020304
          || {input0, input1, input2, input3} !== 32'h090A0B0C) begin
         errors++;
         $display("FAIL reuse_short: en=%0b w=%h%h%h%h i=%h%h%h%h required 1 01020304 090a0b0c",
                  feeder_en, weight0, weight1, weight2, weight3,
                  input0, input1, input2, input3);
      end
      wait_idle();
      host_keep_w = 1'b0;
   endtask
`endif

   initial begin
      checks       = 0;
      errors       = 0;
      rst_n        = 1'b0;
      host_data    = 8'd0;
      host_valid   = 1'b0;
      result_ready = 1'b0;
      done_low3    = 1'b0;
`ifdef WEIGHT_REUSE_EN
      host_keep_w  = 1'b0;
`endif
      test_reset();
      test_basic_job();
      test_backpressure();
      test_error();
`ifdef WEIGHT_REUSE_EN
      test_weight_reuse();
`endif
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
